// File: rtl/piso_shift_register.sv
// Parallel-in / serial-out shift register, MSB first, with a level-sensitive async parallel load.
// Optional feature: define PISO_QH_N_EN to add the inverted serial output qh_n.
module piso_shift_register #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clk_inh,
   input  logic             ser,
   input  logic             sh_ld_n,
   input  logic [WIDTH-1:0] parallel_in,
   output logic [WIDTH-1:0] q,
`ifdef PISO_QH_N_EN
   output logic             qh_n,
`endif
   output logic             qh
);

   logic [WIDTH-1:0] r_lat;
   logic [WIDTH-1:0] r_sh;
   logic             r_sh_vld;
   logic [WIDTH-1:0] w_cur;
   logic [WIDTH-1:0] w_q;

   // Transparent while loading, so the value present when sh_ld_n rises is the one retained.
   always_latch begin
      if (!sh_ld_n) r_lat <= parallel_in;
   end

   // Selects the shift flops over the load latch once a qualifying edge (shift or reset)
   // has occurred after the last load; a new load drops back to the latch asynchronously.
   always_ff @(posedge clk or negedge sh_ld_n) begin
      if (!sh_ld_n)
         r_sh_vld <= 1'b0;
      else if (rst || !clk_inh)
         r_sh_vld <= 1'b1;
   end

   assign w_cur = r_sh_vld ? r_sh : r_lat;

   always_ff @(posedge clk) begin
      if (sh_ld_n) begin
         if (rst)
            r_sh <= '0;
         else if (!clk_inh)
            r_sh <= {w_cur[WIDTH-2:0], ser};
      end
   end

   // ser only reaches q through r_sh; the sole combinational path is parallel_in during load.
   assign w_q = !sh_ld_n ? parallel_in : w_cur;
   assign q   = w_q;
   assign qh  = w_q[WIDTH-1];
`ifdef PISO_QH_N_EN
   assign qh_n = ~w_q[WIDTH-1];
`endif

endmodule

// File: tb/tb_piso_shift_register.sv
// Self-checking bench for piso_shift_register (WIDTH=8) against a rule-level reference model.
module tb_piso_shift_register;

   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic         clk_inh;
   logic         ser;
   logic         sh_ld_n;
   logic [W-1:0] pi;
   logic [W-1:0] q;
   logic         qh;
`ifdef PISO_QH_N_EN
   logic         qh_n;
`endif

   int n_checks = 0;
   int n_pass   = 0;
   logic [W-1:0] m;

   piso_shift_register #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .clk_inh     (clk_inh),
      .ser         (ser),
      .sh_ld_n     (sh_ld_n),
      .parallel_in (pi),
      .q           (q),
`ifdef PISO_QH_N_EN
      .qh_n        (qh_n),
`endif
      .qh          (qh)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Model: load wins, then reset, then inhibit, else shift ser into bit 0.
   task automatic tick();
      if (!sh_ld_n)     m = pi;
      else if (rst)     m = '0;
      else if (!clk_inh) m = {m[W-2:0], ser};
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; clk_inh = 1'b0; sh_ld_n = 1'b1; ser = 1'b1; pi = 8'hFF;
      tick();
      rst = 1'b0;
      n_checks++;
      if (q !== 8'h00) $display("FAIL reset_q got=%h exp=00", q); else n_pass++;
      n_checks++;
      if (qh !== 1'b0) $display("FAIL reset_qh got=%b exp=0", qh); else n_pass++;
   endtask

   task automatic test_async_load();
      #2; sh_ld_n = 1'b0; pi = 8'b10110110;
      #1;
      n_checks++;
      if (q !== 8'b10110110) $display("FAIL aload_q got=%b exp=10110110", q); else n_pass++;
      #1; sh_ld_n = 1'b1; m = 8'b10110110;
      #1;
      n_checks++;
      if (q !== 8'b10110110 || qh !== 1'b1)
         $display("FAIL aload_hold got=%b/%b exp=10110110/1", q, qh);
      else n_pass++;
   endtask

   task automatic test_shift_out();
      logic [W-1:0] seq;
      seq = 8'b10110110;
      ser = 1'b0; clk_inh = 1'b0;
      for (int i = 0; i < W; i++) begin
         n_checks++;
         if (qh !== seq[W-1-i]) $display("FAIL shout_qh%0d got=%b exp=%b", i, qh, seq[W-1-i]);
         else n_pass++;
         tick();
      end
      n_checks++;
      if (q !== 8'h00) $display("FAIL shout_final got=%b exp=00000000", q); else n_pass++;
   endtask

   task automatic test_inhibit();
      clk_inh = 1'b1; ser = 1'b1;
      tick();
      n_checks++;
      if (q !== 8'h00) $display("FAIL inhibit got=%b exp=00000000", q); else n_pass++;
   endtask

   task automatic test_shift_in();
      clk_inh = 1'b0; ser = 1'b1;
      repeat (4) tick();
      n_checks++;
      if (q !== 8'b00001111 || qh !== 1'b0)
         $display("FAIL shin got=%b/%b exp=00001111/0", q, qh);
      else n_pass++;
   endtask

   task automatic test_reset_priority();
      repeat (4) tick();
      n_checks++;
      if (q !== 8'hFF) $display("FAIL rprio_ones got=%h exp=ff", q); else n_pass++;
      rst = 1'b1; clk_inh = 1'b1;
      tick();
      n_checks++;
      if (q !== 8'h00) $display("FAIL rprio_inh got=%h exp=00", q); else n_pass++;
      sh_ld_n = 1'b0; pi = 8'hA5;
      tick();
      n_checks++;
      if (q !== 8'hA5) $display("FAIL rprio_load got=%h exp=a5", q); else n_pass++;
      sh_ld_n = 1'b1; rst = 1'b0; clk_inh = 1'b0;
      #1;
      n_checks++;
      if (q !== 8'hA5) $display("FAIL rprio_release got=%h exp=a5", q); else n_pass++;
   endtask

   task automatic test_load_abort();
      ser = 1'b1; clk_inh = 1'b0;
      #1; sh_ld_n = 1'b0; pi = 8'h3C; #1; sh_ld_n = 1'b1; m = 8'h3C;
      repeat (3) tick();
      #2; sh_ld_n = 1'b0; pi = 8'h81; #1; sh_ld_n = 1'b1; m = 8'h81;
      #1;
      n_checks++;
      if (q !== 8'h81) $display("FAIL abort_load got=%h exp=81", q); else n_pass++;
      ser = 1'b0;
      tick();
      n_checks++;
      if (q !== 8'h02 || qh !== 1'b0) $display("FAIL abort_shift got=%h/%b exp=02/0", q, qh);
      else n_pass++;
   endtask

   task automatic test_qh_n();
`ifdef PISO_QH_N_EN
      #1; sh_ld_n = 1'b0; pi = 8'h80; #1; sh_ld_n = 1'b1; m = 8'h80;
      #1;
      n_checks++;
      if (qh !== 1'b1 || qh_n !== 1'b0) $display("FAIL qhn_load got=%b/%b exp=1/0", qh, qh_n);
      else n_pass++;
      ser = 1'b0; clk_inh = 1'b0; rst = 1'b0;
      tick();
      n_checks++;
      if (qh !== 1'b0 || qh_n !== 1'b1) $display("FAIL qhn_shift got=%b/%b exp=0/1", qh, qh_n);
      else n_pass++;
`endif
   endtask

   task automatic test_random();
      logic [W-1:0] a;
      logic [W-1:0] b;
      for (int i = 0; i < 200; i++) begin
         case ($urandom_range(0, 9))
            0: begin
               a = W'($urandom); b = W'($urandom);
               #1; sh_ld_n = 1'b0; pi = a; rst = 1'($urandom); ser = 1'($urandom);
               #1;
               n_checks++;
               if (q !== a) $display("FAIL rnd_load_a it%0d got=%h exp=%h", i, q, a); else n_pass++;
               pi = b;
               #1;
               n_checks++;
               if (q !== b || qh !== b[W-1]) $display("FAIL rnd_load_b it%0d got=%h exp=%h", i, q, b);
               else n_pass++;
               sh_ld_n = 1'b1; rst = 1'b0; m = b;
               #1;
               n_checks++;
               if (q !== b) $display("FAIL rnd_load_hold it%0d got=%h exp=%h", i, q, b); else n_pass++;
            end
            1: begin
               sh_ld_n = 1'b0; pi = W'($urandom); rst = 1'($urandom); clk_inh = 1'($urandom);
               tick();
               sh_ld_n = 1'b1; rst = 1'b0;
               #1;
               n_checks++;
               if (q !== m) $display("FAIL rnd_ldedge it%0d got=%h exp=%h", i, q, m); else n_pass++;
            end
            default: ;
         endcase
         rst     = ($urandom_range(0, 15) == 0);
         clk_inh = ($urandom_range(0, 3) == 0);
         ser     = 1'($urandom);
         tick();
         n_checks++;
         if (q !== m || qh !== m[W-1]) $display("FAIL rnd_edge it%0d got=%h/%b exp=%h/%b", i, q, qh, m, m[W-1]);
         else n_pass++;
      end
      rst = 1'b0; clk_inh = 1'b0;
   endtask

   initial begin
      rst = 1'b0; clk_inh = 1'b0; ser = 1'b0; sh_ld_n = 1'b1; pi = '0; m = '0;
      @(posedge clk);
      #1;
      test_reset();
      test_async_load();
      test_shift_out();
      test_inhibit();
      test_shift_in();
      test_reset_priority();
      test_load_abort();
      test_qh_n();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/piso_shift_register.md
PISO_SHIFT_REGISTER -- requirements
Module: piso_shift_register

Interface
REQ-001 Parameter: WIDTH, default 8, register length in bits (legal range 2..64).
REQ-002 Port: clk  input  1  rising-edge clock for all synchronous behaviour.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: clk_inh  input  1  clock inhibit; high holds the register on clk edges.
REQ-005 Port: ser  input  1  serial data shifted into bit 0.
REQ-006 Port: sh_ld_n  input  1  low = parallel load (asynchronous, level-sensitive); high = shift mode.
REQ-007 Port: parallel_in  input  WIDTH  parallel load data.
REQ-008 Port: q  output  WIDTH  full register contents.
REQ-009 Port: qh  output  1  serial output, always equal to q[WIDTH-1].
REQ-010 Clock and reset: one clock (clk); rst is synchronous and active-high.

Function
REQ-011 While sh_ld_n is low, q SHALL equal parallel_in immediately and asynchronously, independent of clk, clk_inh, rst and ser.
REQ-012 Parallel-input changes while sh_ld_n is low SHALL propagate to q without waiting for a clock edge.
REQ-013 On sh_ld_n rising, q SHALL hold the last loaded value until the next qualifying clk edge.
REQ-014 On a rising clk edge with sh_ld_n high, rst low and clk_inh low, q SHALL become {q[WIDTH-2:0], ser}.
REQ-015 MSB goes out first: qh presents the loaded MSB before the first shift, then the next lower bit after each shift.
REQ-016 On a rising clk edge with sh_ld_n high, rst low and clk_inh high, q SHALL be unchanged.
REQ-017 ser is sampled only on qualifying shift edges; it is ignored during load, inhibit and reset.
REQ-018 Priority, highest first: asynchronous load (sh_ld_n low), then synchronous reset, then inhibit, then shift.
REQ-019 After WIDTH shifts, every loaded bit has left qh and q holds the last WIDTH ser samples.
REQ-020 sh_ld_n asserted mid-shift SHALL abort the sequence and overwrite q with no partial-shift residue.
REQ-021 The block SHALL contain no combinational path from ser to qh; its only combinational path is parallel_in to q/qh while sh_ld_n is low.

Reset
REQ-022 On a rising clk edge with rst high and sh_ld_n high, q SHALL become all zeros and qh SHALL become 0.
REQ-023 rst SHALL override clk_inh.
REQ-024 rst SHALL NOT override an active load: with sh_ld_n low, q keeps following parallel_in.
REQ-025 Before the first reset or load, q is undefined; benches SHALL reset or load before checking outputs.

Configuration
REQ-026 With macro PISO_QH_N_EN defined, the module SHALL add the output port qh_n (1 bit), always equal to ~qh, including during load and reset.
REQ-027 Without PISO_QH_N_EN, qh_n SHALL be absent and all other behaviour is identical.

Verification
REQ-028 Async load: WIDTH=8, pulse sh_ld_n low for 2 ns between clk edges with parallel_in=8'b10110110 -> q=10110110 and qh=1 before the next clk edge.
REQ-029 Shift out: after the load, ser=0, clk_inh=0, 8 clk edges -> qh sequence 1,0,1,1,0,1,1,0 and final q=00000000.
REQ-030 Inhibit: clk_inh=1, ser=1, 1 clk edge -> q stays 00000000.
REQ-031 Shift in: clk_inh=0, ser=1, 4 clk edges -> q=00001111 and qh=0.
REQ-032 Reset priority: q=11111111, rst=1 with clk_inh=1 -> q=00000000 after one edge; repeat with sh_ld_n=0 and parallel_in=8'hA5 -> q=A5.
REQ-033 Config: build with PISO_QH_N_EN, load 8'h80 -> qh=1 and qh_n=0; after one shift with ser=0 -> qh=0 and qh_n=1.
